pmod_capture: RTL and testbench
===============================

PMOD_CAPTURE -- requirements
Module: pmod_capture

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, sets the CLK cycles per UART bit; legal values are 2..65535.
REQ-002 Parameter CHANGE_ONLY, default 1; when 1, a sample is queued only if it differs from the previous sample; when 0, every sample is queued.
REQ-003 CLK  input  1  system clock; all logic SHALL be on posedge CLK.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 dut_clk_in  input  1  DUT clock from PMOD, asynchronous to CLK, slower than CLK/4.
REQ-006 dut_data_in  input  8  DUT output bus from PMOD, asynchronous to CLK.
REQ-007 tx  output  1  UART 8N1 serial out, idle high.
REQ-008 tx_busy  output  1  high while a frame is in progress.
REQ-009 overflow  output  1  sticky flag: a sample was dropped because the FIFO was full.
REQ-010 fifo_level  output  3  number of queued bytes, 0..4.

Function
REQ-011 dut_clk_in and each dut_data_in bit SHALL pass through a 2-flop synchronizer of equal depth.
REQ-012 A rising edge SHALL be detected when the synchronized clock is 1 and its previous registered value is 0; this yields a one-cycle capture pulse.
REQ-013 On the capture pulse, the synchronized data byte SHALL be sampled as "sample".
REQ-014 With CHANGE_ONLY=1, sample is pushed if it differs from last_sample or if first_flag is set; last_sample updates on every capture pulse, and first_flag clears on the first push.
REQ-015 The FIFO SHALL be 4 deep and first-in first-out, and a push becomes visible in fifo_level the cycle after the capture pulse.
REQ-016 A push while full with no simultaneous pop is dropped, and overflow is set the next cycle and held until rst.
REQ-017 A push and a pop in the same cycle while full SHALL both succeed, leaving fifo_level at 4 with no overflow.
REQ-018 A pop while empty is never issued.
REQ-019 The UART FSM has states IDLE, START, DATA, STOP.
REQ-020 IDLE with fifo_level>0: pop the head byte into the shift register and go to START in the same cycle.
REQ-021 START drives tx=0 for CLKS_PER_BIT cycles, then goes to DATA.
REQ-022 DATA drives 8 bits LSB first, each for CLKS_PER_BIT cycles, then goes to STOP.
REQ-023 STOP drives tx=1 for CLKS_PER_BIT cycles, then goes to IDLE.
REQ-024 One frame SHALL be exactly 10*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-025 Back-to-back frames are separated by exactly 1 IDLE cycle.
REQ-026 tx_busy = (state != IDLE), registered, and aligned with tx.
REQ-027 The bit counter is 3 bits and the baud counter is 16 bits; both reload to 0 on each bit boundary, with no wrap-around beyond the terminal count.
REQ-028 A capture during an active frame SHALL queue normally without disturbing the frame.

Reset
REQ-029 While rst=1 at a CLK edge, the following SHALL be forced:
- tx=1, tx_busy=0, overflow=0, fifo_level=0;
- FSM=IDLE, FIFO pointers 0;
- synchronizers, edge-history flop and last_sample all 0;
- first_flag=1.
REQ-030 rst asserted mid-frame SHALL abort the frame, return tx high on the next cycle, and discard FIFO contents.
REQ-031 After rst deasserts, the synchronized clock starting at 1 SHALL NOT produce a capture pulse on the first cycle (history flop is 0, so a pulse is allowed only after a 0 has been seen).

Verification
REQ-032 The bench SHALL run with CLKS_PER_BIT=4 and CHANGE_ONLY=1 unless stated otherwise.
REQ-033 Single capture: dut_data_in=0xA5, one dut_clk_in rising edge -> tx shows 0,1,0,1,0,0,1,0,1,1, 4 cycles per bit, 40 cycles total, with tx_busy high throughout.
REQ-034 Change filter: 3 edges with data 0x3C,0x3C,0x81 -> exactly 2 frames, 0x3C then 0x81; with CHANGE_ONLY=0 -> 3 frames.
REQ-035 First sample 0x00 after reset -> one frame carrying 0x00, because first_flag overrides the change filter.
REQ-036 Overflow: 6 distinct bytes at edge spacing of 8 CLK cycles during the first frame -> 1 popped byte plus 4 queued, 1 dropped, overflow=1 and fifo_level=4 at peak, and the dropped byte never appears on tx.
REQ-037 Reset mid-frame: rst pulsed during DATA bit 3 -> next cycle tx=1, tx_busy=0, fifo_level=0, and no further frames are sent.
REQ-038 Back-to-back: 2 queued bytes -> a gap of exactly 1 cycle of tx=1 between the stop bit of frame 1 and the start bit of frame 2.

Source files
------------

// File: rtl/pmod_capture.sv
// pmod_capture: samples an 8-bit PMOD bus on rising edges of an asynchronous DUT clock,
// queues the bytes in a 4-entry FIFO and streams them out as UART 8N1 frames.
module pmod_capture #(
   parameter int CLKS_PER_BIT = 104,
   parameter int CHANGE_ONLY  = 1
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       dut_clk_in,
   input  logic [7:0] dut_data_in,
   output logic       tx,
   output logic       tx_busy,
   output logic       overflow,
   output logic [2:0] fifo_level
);
   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic       clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_hist_q, clk_hist_d;
   logic [7:0] dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic [7:0] last_q, last_d;
   logic       first_q, first_d;
   logic [7:0] mem_q [4];
   logic [7:0] mem_d [4];
   logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0] count_q, count_d;
   logic       ovf_q, ovf_d;
   logic       cap, want_push, push, pop;

   state_t      state_q;
   logic [15:0] baud_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic        tx_q, busy_q;

   always_comb begin
      clk_s1_d   = dut_clk_in;
      clk_s2_d   = clk_s1_q;
      clk_hist_d = clk_s2_q;
      dat_s1_d   = dut_data_in;
      dat_s2_d   = dat_s1_q;

      cap       = clk_s2_q & ~clk_hist_q;
      want_push = cap & ((CHANGE_ONLY == 0) | first_q | (dat_s2_q != last_q));
      pop       = (state_q == IDLE) & (count_q != 3'd0);
      // a simultaneous pop frees the slot, so a full FIFO still accepts the push
      push      = want_push & ((count_q != 3'd4) | pop);

      last_d  = cap ? dat_s2_q : last_q;
      first_d = first_q & ~push;

      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = dat_s2_q;
      wr_ptr_d = wr_ptr_q + 2'(push);
      rd_ptr_d = rd_ptr_q + 2'(pop);
      count_d  = count_q + 3'(push) - 3'(pop);
      ovf_d    = ovf_q | (want_push & ~push);
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         clk_s1_q   <= 1'b0;
         clk_s2_q   <= 1'b0;
         clk_hist_q <= 1'b0;
         dat_s1_q   <= '0;
         dat_s2_q   <= '0;
         last_q     <= '0;
         first_q    <= 1'b1;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         clk_hist_q <= clk_hist_d;
         dat_s1_q   <= dat_s1_d;
         dat_s2_q   <= dat_s2_d;
         last_q     <= last_d;
         first_q    <= first_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
      end
   end

   // tx and tx_busy are registered together so they switch on the same edge
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= START;
               end
            end
            START: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            DATA: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     tx_q    <= shift_q[1];
                     shift_q <= {1'b0, shift_q[7:1]};
                  end
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            STOP: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q  <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx         = tx_q;
   assign tx_busy    = busy_q;
   assign overflow   = ovf_q;
   assign fifo_level = count_q;
endmodule

// File: tb/tb_pmod_capture.sv
// Bench for pmod_capture: two instances (change filter on / off) share the stimulus;
// a tx decoder collects frames and a timing-level FIFO model predicts the byte stream.
module tb_pmod_capture;
   localparam int CPB    = 4;
   localparam int PERIOD = 10 * CPB + 1;   // pop-to-pop spacing of back-to-back frames

   logic       CLK = 1'b0;
   logic       rst = 1'b1;
   logic       dut_clk_in = 1'b0;
   logic [7:0] dut_data_in = 8'h00;
   logic [1:0] tx, tx_busy, overflow;
   logic [2:0] lvl [2];

   pmod_capture #(.CLKS_PER_BIT(CPB), .CHANGE_ONLY(1)) dut (
      .CLK(CLK), .rst(rst), .dut_clk_in(dut_clk_in), .dut_data_in(dut_data_in),
      .tx(tx[0]), .tx_busy(tx_busy[0]), .overflow(overflow[0]), .fifo_level(lvl[0]));

   pmod_capture #(.CLKS_PER_BIT(CPB), .CHANGE_ONLY(0)) dut_all (
      .CLK(CLK), .rst(rst), .dut_clk_in(dut_clk_in), .dut_data_in(dut_data_in),
      .tx(tx[1]), .tx_busy(tx_busy[1]), .overflow(overflow[1]), .fifo_level(lvl[1]));

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // ---------------- tx decoder (records only, never checks) ----------------
   logic [39:0] fbits [2];
   int          flen [2], got_n [2], gap [2], idle_cnt [2], idle_bad [2], fmt_bad [2], peak [2];
   logic [7:0]  got [2][64];
   bit          prev_busy [2];

   always @(negedge CLK) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            flen[d] = 0; prev_busy[d] = 1'b0; peak[d] = 0; idle_cnt[d] = 0;
         end else begin
            if (int'(lvl[d]) > peak[d]) peak[d] = int'(lvl[d]);
            if (tx_busy[d]) begin
               if (!prev_busy[d]) begin
                  gap[d] = idle_cnt[d]; idle_cnt[d] = 0; flen[d] = 0;
               end
               if (flen[d] < 40) fbits[d][flen[d]] = tx[d];
               flen[d]++;
            end else begin
               if (tx[d] !== 1'b1) idle_bad[d]++;
               if (prev_busy[d]) begin
                  logic ok;
                  logic [7:0] b;
                  ok = (flen[d] == 40);
                  for (int g = 0; g < 10; g++)
                     for (int k = 1; k < 4; k++)
                        if (fbits[d][g*4+k] !== fbits[d][g*4]) ok = 1'b0;
                  if (fbits[d][0] !== 1'b0 || fbits[d][36] !== 1'b1) ok = 1'b0;
                  if (!ok) fmt_bad[d]++;
                  for (int i = 0; i < 8; i++) b[i] = fbits[d][4 + 4*i];
                  if (got_n[d] < 64) begin got[d][got_n[d]] = b; got_n[d]++; end
               end
               idle_cnt[d]++;
            end
            prev_busy[d] = tx_busy[d];
         end
      end
   end

   // ---------------- checking ----------------
   int errors = 0, checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // A byte captured in cycle c is dropped when four accepted bytes are still waiting
   // for a pop after c; otherwise it is popped at max(c+1, previous pop + PERIOD).
   int         m_pop  [2][64];
   logic [7:0] m_byte [2][64];
   int         m_n [2], base [2];
   logic [7:0] m_last [2];
   bit         m_first [2], m_ovf [2];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_n[d] = 0; m_last[d] = 8'h00; m_first[d] = 1'b1; m_ovf[d] = 1'b0; base[d] = got_n[d];
      end
   endtask

   task automatic model_cap(input logic [7:0] v, input int c);
      int occ, p;
      for (int d = 0; d < 2; d++) begin
         if (d == 1 || m_first[d] || v != m_last[d]) begin
            occ = 0;
            for (int j = 0; j < m_n[d]; j++) if (m_pop[d][j] > c) occ++;
            if (occ >= 4) m_ovf[d] = 1'b1;
            else begin
               p = c + 1;
               if (m_n[d] > 0 && m_pop[d][m_n[d]-1] + PERIOD > p) p = m_pop[d][m_n[d]-1] + PERIOD;
               m_pop[d][m_n[d]] = p; m_byte[d][m_n[d]] = v; m_n[d]++;
               m_first[d] = 1'b0;
            end
         end
         m_last[d] = v;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(posedge CLK); #1 rst = 1'b1; dut_clk_in = 1'b0;
      repeat (2) @(posedge CLK);
      #1 rst = 1'b0;
      model_reset();
   endtask

   // one DUT clock period of 8 CLK cycles, data set up 4 cycles ahead of the rising edge
   task automatic edge_cap(input logic [7:0] v);
      dut_data_in = v;
      repeat (4) @(posedge CLK);
      #1 dut_clk_in = 1'b1;
      model_cap(v, cyc + 2);
      repeat (4) @(posedge CLK);
      #1 dut_clk_in = 1'b0;
   endtask

   task automatic wait_frames(input string tag, input int budget);
      int t;
      t = 0;
      while ((got_n[0] - base[0] < m_n[0] || got_n[1] - base[1] < m_n[1]) && t < budget) begin
         @(posedge CLK); t++;
      end
      check({tag, "_in_time"}, 32'(t < budget), 32'd1);
      repeat (10) @(posedge CLK);
      #1;
   endtask

   task automatic compare_frames(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s_count%0d", tag, d), got_n[d] - base[d], m_n[d]);
         for (int i = 0; i < m_n[d] && base[d] + i < got_n[d]; i++)
            check($sformatf("%s_byte%0d_%0d", tag, d, i), got[d][base[d]+i], m_byte[d][i]);
         check($sformatf("%s_fmt%0d", tag, d), fmt_bad[d], 0);
         check($sformatf("%s_ovf%0d", tag, d), overflow[d], m_ovf[d]);
      end
   endtask

   initial begin
      logic [7:0] v;
      int t;

      // reset state
      do_reset();
      check("rst_tx", tx[0], 1);
      check("rst_busy", tx_busy[0], 0);
      check("rst_ovf", overflow[0], 0);
      check("rst_level", lvl[0], 0);
      check("rst_tx_all", tx[1], 1);

      // single capture of 0xA5
      edge_cap(8'hA5);
      wait_frames("a5", 300);
      compare_frames("a5");
      check("a5_value", got[0][base[0]], 8'hA5);

      // change filter: 3C, 3C, 81
      do_reset();
      edge_cap(8'h3C); repeat (50) @(posedge CLK); #1;
      edge_cap(8'h3C); repeat (50) @(posedge CLK); #1;
      edge_cap(8'h81);
      wait_frames("cf", 400);
      compare_frames("cf");
      check("cf_frames_filtered", got_n[0] - base[0], 2);
      check("cf_frames_all", got_n[1] - base[1], 3);

      // first sample 0x00 after reset
      do_reset();
      edge_cap(8'h00);
      wait_frames("zero", 300);
      compare_frames("zero");
      check("zero_frames", got_n[0] - base[0], 1);

      // overflow: six distinct bytes, one DUT edge every 8 cycles
      do_reset();
      for (int i = 0; i < 6; i++) edge_cap(8'h10 + 8'(i * 17));
      wait_frames("ovf", 600);
      compare_frames("ovf");
      check("ovf_frames", got_n[0] - base[0], 5);
      check("ovf_flag", overflow[0], 1);
      check("ovf_peak", peak[0], 4);

      // back-to-back: two bytes queued close together
      do_reset();
      edge_cap(8'h5A);
      edge_cap(8'hC3);
      wait_frames("b2b", 300);
      compare_frames("b2b");
      check("b2b_gap", gap[0], 1);

      // reset during DATA bit 3 of the first of two queued frames
      do_reset();
      edge_cap(8'h77);
      t = 0;
      while (!tx_busy[0] && t < 50) begin @(posedge CLK); #1; t++; end
      check("rmf_started", tx_busy[0], 1);
      edge_cap(8'h99);
      repeat (8) @(posedge CLK);
      #1;
      check("rmf_level_before", lvl[0], 1);
      rst = 1'b1;
      @(posedge CLK); #1;
      check("rmf_tx", tx[0], 1);
      check("rmf_busy", tx_busy[0], 0);
      check("rmf_level", lvl[0], 0);
      rst = 1'b0;
      model_reset();
      repeat (200) @(posedge CLK);
      #1;
      check("rmf_no_frames", got_n[0] - base[0], 0);
      check("rmf_no_frames_all", got_n[1] - base[1], 0);
      check("rmf_idle", tx_busy[0], 0);

      // randomized captures from a small alphabet so repeats occur
      do_reset();
      for (int i = 0; i < 14; i++) begin
         v = 8'h50 + 8'($urandom_range(0, 3));
         edge_cap(v);
         repeat ($urandom_range(0, 40)) @(posedge CLK);
         #1;
      end
      wait_frames("rnd", 1500);
      compare_frames("rnd");

      check("idle_high0", idle_bad[0], 0);
      check("idle_high1", idle_bad[1], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
